ladybird_level_fifo: RTL and testbench

Parametrised successor to the team's single-clock valid/ready FIFO. Buffers `DATA_W`-bit words between a producer (`a_*`) and a consumer (`b_*`) port, and adds occupancy reporting, programmable almost-full/almost-empty flags and a one-cycle `clear` flush. An optional registered output stage is available for timing closure. Sits between stream-processing stages where upstream throttling must start before hard backpressure.

---
 rtl/ladybird_level_fifo_if.sv | 14 +
 rtl/ladybird_level_fifo.sv | 128 ++++++++++++
 tb/tb_ladybird_level_fifo.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ladybird_level_fifo_if.sv
// Stream interface for ladybird_level_fifo: producer (a_*) and consumer (b_*) handshakes.
interface ladybird_level_fifo_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] a_data;
  logic              a_valid;
  logic              a_ready;
  logic [DATA_W-1:0] b_data;
  logic              b_valid;
  logic              b_ready;

  modport master (output a_data, a_valid, b_ready, input a_ready, b_data, b_valid);
  modport slave  (input a_data, a_valid, b_ready, output a_ready, b_data, b_valid);
endinterface

// File: rtl/ladybird_level_fifo.sv
// Single-clock valid/ready FIFO with occupancy, almost-full/almost-empty flags and clear flush.
// Define LADYBIRD_FIFO_OUTREG_EN to take b_data/b_valid from a register stage (capacity D+1).
module ladybird_level_fifo #(
  parameter int FIFO_DEPTH_W = 4,
  parameter int DATA_W       = 8,
  parameter int AFULL_TH     = (2 ** FIFO_DEPTH_W) - 2,
  parameter int AEMPTY_TH    = 1
) (
  input  logic                    clk,
  input  logic                    anrst,
  input  logic                    nrst,
  input  logic                    clear,
  ladybird_level_fifo_if.slave    bus,
  output logic [FIFO_DEPTH_W:0]   level,
  output logic                    almost_full,
  output logic                    almost_empty
);
  localparam int D  = 2 ** FIFO_DEPTH_W;
  localparam int LW = FIFO_DEPTH_W + 1;
  localparam logic [LW-1:0]           DEPTH_L  = LW'(D);
  localparam logic [LW-1:0]           LVL_ZERO = LW'(0);
  localparam logic [LW-1:0]           LVL_ONE  = LW'(1);
  localparam logic [LW-1:0]           AFULL_L  = LW'(AFULL_TH);
  localparam logic [LW-1:0]           AEMPTY_L = LW'(AEMPTY_TH);
  localparam logic [FIFO_DEPTH_W-1:0] PTR_ONE  = FIFO_DEPTH_W'(1);

  logic [DATA_W-1:0]       mem_r [D];
  logic [FIFO_DEPTH_W-1:0] rd_ptr_r;
  logic [FIFO_DEPTH_W-1:0] wr_ptr_r;
  logic [LW-1:0]           level_mem_r;
  logic [LW-1:0]           level_mem_nxt_s;
  logic [LW-1:0]           level_s;
  logic [DATA_W-1:0]       head_s;
  logic                    a_ready_s;
  logic                    wr_fire_s;
  logic                    rd_mem_s;

  assign head_s    = mem_r[rd_ptr_r];
  assign a_ready_s = (level_mem_r != DEPTH_L);
  assign wr_fire_s = bus.a_valid & a_ready_s;
  assign bus.a_ready = a_ready_s;

`ifdef LADYBIRD_FIFO_OUTREG_EN
  logic              out_valid_r;
  logic              out_valid_nxt_s;
  logic [DATA_W-1:0] out_data_r;

  // Output stage refills whenever it is empty or being consumed.
  always_comb begin
    rd_mem_s = (~out_valid_r | bus.b_ready) & (level_mem_r != LVL_ZERO);
    if (rd_mem_s) begin
      out_valid_nxt_s = 1'b1;
    end else if (bus.b_ready) begin
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
  end

  // Output register stage.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
    end else if (!nrst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
    end else if (clear) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
    end else begin
      out_valid_r <= out_valid_nxt_s;
      out_data_r  <= rd_mem_s ? head_s : out_data_r;
    end
  end

  assign bus.b_valid = out_valid_r;
  assign bus.b_data  = out_data_r;
  assign level_s     = level_mem_r + LW'(out_valid_r);
`else
  assign rd_mem_s    = (level_mem_r != LVL_ZERO) & bus.b_ready;
  assign bus.b_valid = (level_mem_r != LVL_ZERO);
  assign bus.b_data  = head_s;
  assign level_s     = level_mem_r;
`endif

  // Memory occupancy update; a simultaneous read and write leaves it unchanged.
  always_comb begin
    level_mem_nxt_s = level_mem_r;
    case ({wr_fire_s, rd_mem_s})
      2'b10:   level_mem_nxt_s = level_mem_r + LVL_ONE;
      2'b01:   level_mem_nxt_s = level_mem_r - LVL_ONE;
      default: level_mem_nxt_s = level_mem_r;
    endcase
  end

  // Pointers and occupancy register.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      rd_ptr_r    <= {FIFO_DEPTH_W{1'b0}};
      wr_ptr_r    <= {FIFO_DEPTH_W{1'b0}};
      level_mem_r <= {LW{1'b0}};
    end else if (!nrst || clear) begin
      rd_ptr_r    <= {FIFO_DEPTH_W{1'b0}};
      wr_ptr_r    <= {FIFO_DEPTH_W{1'b0}};
      level_mem_r <= {LW{1'b0}};
    end else begin
      rd_ptr_r    <= rd_mem_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      wr_ptr_r    <= wr_fire_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      level_mem_r <= level_mem_nxt_s;
    end
  end

  // Storage array; clear leaves contents in place, reset zeroes them.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      for (int i = 0; i < D; i++) mem_r[i] <= {DATA_W{1'b0}};
    end else if (!nrst) begin
      for (int i = 0; i < D; i++) mem_r[i] <= {DATA_W{1'b0}};
    end else if (wr_fire_s && !clear) begin
      mem_r[wr_ptr_r] <= bus.a_data;
    end
  end

  assign level        = level_s;
  assign almost_full  = (level_s >= AFULL_L);
  assign almost_empty = (level_s <= AEMPTY_L);
endmodule

// File: tb/tb_ladybird_level_fifo.sv
// Self-checking bench for ladybird_level_fifo (default D=16, AFULL_TH=14, AEMPTY_TH=1).
module tb_ladybird_level_fifo;
  logic       clk = 1'b0;
  logic       anrst = 1'b0;
  logic       nrst = 1'b1;
  logic       clear = 1'b0;
  logic [4:0] level;
  logic       almost_full;
  logic       almost_empty;
  int         pass_cnt = 0;
  int         chk_cnt = 0;

  ladybird_level_fifo_if #(.DATA_W(8)) bus ();

  ladybird_level_fifo dut (
    .clk(clk), .anrst(anrst), .nrst(nrst), .clear(clear), .bus(bus),
    .level(level), .almost_full(almost_full), .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       av; logic [7:0] ad; logic br; logic clr; logic nr;
    logic       ar; logic bv; logic [7:0] bd; logic [4:0] lv; logic dchk;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic av, input int ad, input logic br, input logic clr,
                              input logic nr, input logic ar, input logic bv, input int bd,
                              input int lv, input logic dchk);
    vec_t v;
    v.av = av; v.ad = 8'(ad); v.br = br; v.clr = clr; v.nr = nr;
    v.ar = ar; v.bv = bv; v.bd = 8'(bd); v.lv = 5'(lv); v.dchk = dchk;
    return v;
  endfunction

  task automatic drive(input logic av, input logic [7:0] ad, input logic br);
    bus.a_valid = av; bus.a_data = ad; bus.b_ready = br;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] wdata;
    logic       wr;
    logic       rd;
    int         accepted;
    drive(1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_ready", int'(bus.a_ready), 1);
    chk("rst_b_valid", int'(bus.b_valid), 0);
    chk("rst_b_data", int'(bus.b_data), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_afull", int'(almost_full), 0);
    chk("rst_aempty", int'(almost_empty), 1);
    anrst = 1'b1;
    @(negedge clk);

`ifdef LADYBIRD_FIFO_OUTREG_EN
    drive(1'b1, 8'h51, 1'b0);
    @(posedge clk); #1;
    chk("or_bvalid_n", int'(bus.b_valid), 0);
    chk("or_level_n", int'(level), 1);
    drive(1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;
    chk("or_bvalid_n1", int'(bus.b_valid), 1);
    chk("or_bdata_n1", int'(bus.b_data), 8'h51);
    accepted = 1;
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, 8'(8'h52 + accepted - 1), 1'b0);
      wr = bus.a_ready;
      @(posedge clk); #1;
      if (wr) accepted++;
    end
    chk("or_capacity", accepted, 17);
    chk("or_level_full", int'(level), 17);
    chk("or_a_ready_full", int'(bus.a_ready), 0);
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 17; i++) begin
      chk("or_drain_data", int'(bus.b_data), 8'h51 + i);
      @(posedge clk); #1;
    end
    chk("or_empty_bvalid", int'(bus.b_valid), 0);
`else
    // Table: sync reset beats a write, fill, full corner, drain, clear and nrst.
    tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 1, 0, 8'h00, 0, 1));
    for (int k = 1; k <= 16; k++) tbl.push_back(mk(1, 8'h10 + k, 0, 0, 1, k != 16, 1, 8'h11, k, 1));
    tbl.push_back(mk(1, 8'h99, 0, 0, 1, 0, 1, 8'h11, 16, 1));
    tbl.push_back(mk(1, 8'h21, 1, 0, 1, 1, 1, 8'h12, 15, 1));
    tbl.push_back(mk(1, 8'h21, 0, 0, 1, 0, 1, 8'h12, 16, 1));
    for (int j = 1; j <= 16; j++) tbl.push_back(mk(0, 0, 1, 0, 1, 1, j != 16, 8'h12 + j, 16 - j, j != 16));
    tbl.push_back(mk(1, 8'h31, 1, 0, 1, 1, 1, 8'h31, 1, 1));
    for (int k = 2; k <= 8; k++) tbl.push_back(mk(1, 8'h30 + k, 0, 0, 1, 1, 1, 8'h31, k, 1));
    tbl.push_back(mk(1, 8'h77, 1, 1, 1, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 8'h42, 0, 0, 1, 1, 1, 8'h42, 1, 1));
    tbl.push_back(mk(1, 8'h45, 0, 0, 1, 1, 1, 8'h42, 2, 1));
    tbl.push_back(mk(1, 8'h46, 1, 1, 0, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(1, 8'h43, 0, 0, 1, 1, 1, 8'h43, 1, 1));

    foreach (tbl[i]) begin
      drive(tbl[i].av, tbl[i].ad, tbl[i].br);
      clear = tbl[i].clr; nrst = tbl[i].nr;
      @(posedge clk); #1;
      chk($sformatf("v%0d_a_ready", i), int'(bus.a_ready), int'(tbl[i].ar));
      chk($sformatf("v%0d_b_valid", i), int'(bus.b_valid), int'(tbl[i].bv));
      chk($sformatf("v%0d_level", i), int'(level), int'(tbl[i].lv));
      chk($sformatf("v%0d_afull", i), int'(almost_full), int'(tbl[i].lv >= 5'd14));
      chk($sformatf("v%0d_aempty", i), int'(almost_empty), int'(tbl[i].lv <= 5'd1));
      if (tbl[i].dchk) chk($sformatf("v%0d_b_data", i), int'(bus.b_data), int'(tbl[i].bd));
    end
    clear = 1'b0; nrst = 1'b1;

    // Async reset in the middle of a cycle with data stored.
    drive(1'b1, 8'h55, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #2 anrst = 1'b0;
    #1;
    chk("arst_level", int'(level), 0);
    chk("arst_b_valid", int'(bus.b_valid), 0);
    chk("arst_a_ready", int'(bus.a_ready), 1);
    chk("arst_b_data", int'(bus.b_data), 0);
    @(negedge clk);
    anrst = 1'b1;
    drive(1'b1, 8'h44, 1'b0);
    @(posedge clk); #1;
    chk("arst_new_data", int'(bus.b_data), 8'h44);
    chk("arst_new_level", int'(level), 1);

    // Streaming with random consumer gaps against a queue model.
    q.push_back(8'h44);
    wdata = 8'h60;
    for (int c = 0; c < 100; c++) begin
      chk("stream_b_valid", int'(bus.b_valid), int'(q.size() != 0));
      chk("stream_a_ready", int'(bus.a_ready), int'(q.size() != 16));
      chk("stream_level", int'(level), q.size());
      drive(1'b1, wdata, ($urandom_range(0, 3) != 0));
      wr = (q.size() != 16);
      rd = (q.size() != 0) && bus.b_ready;
      if (rd) begin
        chk("stream_b_data", int'(bus.b_data), int'(q[0]));
        void'(q.pop_front());
      end
      if (wr) begin
        q.push_back(wdata);
        wdata = wdata + 8'd1;
      end
      @(posedge clk); #1;
    end
`endif
    drive(1'b0, 8'h00, 1'b0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
